inventory_store: RTL and testbench

- Stock-count memory and responder for the dispensing controller's inventory port: zero-latency read, guarded write commit.
- Second port (restock) lets the service/maintenance logic add or set per-item stock with a valid/ready handshake and read-modify-write FSM.
- Produces registered low/empty flags per item and a dispense event counter for the status/telemetry path.

---
 rtl/inventory_store.sv | 189 ++++++++++++++++++
 tb/tb_inventory_store.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inventory_store.sv
// Per-item stock memory: combinational read port for the dispensing controller,
// a restock port with a read-modify-write FSM, registered low/empty flags and a vend counter.
module inventory_store #(
    parameter int NUM_ITEMS  = 16,
    parameter int INIT_STOCK = 10,
    parameter int LOW_THRESH = 2,
    parameter int MAX_STOCK  = 999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           inv_addr,
    input  logic [15:0]          inv_wdata,
    input  logic                 inv_we,
    output logic [15:0]          inv_rdata,
    input  logic                 rs_valid,
    output logic                 rs_ready,
    input  logic [3:0]           rs_item,
    input  logic [15:0]          rs_qty,
    input  logic                 rs_mode,
    output logic                 rs_done,
    output logic [NUM_ITEMS-1:0] low_stock,
    output logic [NUM_ITEMS-1:0] empty,
    output logic [31:0]          vend_count,
    output logic                 rs_state
);

    localparam int          AW         = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam logic [8:0]  NUM_V      = 9'(NUM_ITEMS);
    localparam logic [15:0] INIT_V     = 16'(INIT_STOCK);
    localparam logic [15:0] LOW_V      = 16'(LOW_THRESH);
    localparam logic [16:0] MAX_V      = 17'(MAX_STOCK);
    localparam logic        INIT_LOW   = (INIT_V <= LOW_V);
    localparam logic        INIT_EMPTY = (INIT_V == 16'd0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } rs_state_t;

    logic [15:0]   stock [NUM_ITEMS];
    rs_state_t     state_q, state_d;

    logic          prev_we;
    logic [7:0]    prev_addr;
    logic [15:0]   prev_wdata;

    logic [3:0]    item_q;
    logic [15:0]   qty_q;
    logic          mode_q;

    logic          inv_in_range;
    logic [AW-1:0] inv_idx;
    logic          ctrl_commit;
    logic          vend_dec;
    logic          rs_accept;

    logic [7:0]    item_ext;
    logic [AW-1:0] item_idx;
    logic          item_in_range;
    logic [16:0]   rmw_sum;
    logic [16:0]   rmw_raw;
    logic [15:0]   apply_data;
    logic          apply_we;

    assign inv_in_range = ({1'b0, inv_addr} < NUM_V);
    assign inv_idx      = inv_addr[AW-1:0];

    always_comb begin
        inv_rdata = '0;
        if (inv_in_range) begin
            inv_rdata = stock[inv_idx];
        end
    end

    // A held write level only commits on its first cycle or when addr/data change.
    assign ctrl_commit = inv_we && inv_in_range &&
                         (!prev_we || (inv_addr != prev_addr) || (inv_wdata != prev_wdata));
    assign vend_dec    = (inv_wdata < inv_rdata);

    // Restock handshake: a request transfers on a cycle where rs_valid and rs_ready
    // are both high; rs_ready is registered and low for the whole APPLY phase.
    assign rs_accept = rs_valid && rs_ready;

    assign item_ext      = {4'b0000, item_q};
    assign item_idx      = item_ext[AW-1:0];
    assign item_in_range = ({1'b0, item_ext} < NUM_V);

    // 17-bit sum so an add never wraps before the ceiling clamp.
    assign rmw_sum    = {1'b0, stock[item_idx]} + {1'b0, qty_q};
    assign rmw_raw    = mode_q ? {1'b0, qty_q} : rmw_sum;
    assign apply_data = (rmw_raw > MAX_V) ? MAX_V[15:0] : rmw_raw[15:0];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a controller commit in APPLY stalls the restock one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rs_accept) state_d = S_APPLY;
            S_APPLY: if (!ctrl_commit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        rs_done  = 1'b0;
        apply_we = 1'b0;
        if ((state_q == S_APPLY) && !ctrl_commit && !rst) begin
            rs_done  = 1'b1;
            apply_we = item_in_range;
        end
    end

    assign rs_state = (state_q == S_APPLY);

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_ready <= 1'b0;
        end else begin
            rs_ready <= (state_d == S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            item_q <= '0;
            qty_q  <= '0;
            mode_q <= 1'b0;
        end else if (rs_accept) begin
            item_q <= rs_item;
            qty_q  <= rs_qty;
            mode_q <= rs_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_we    <= 1'b0;
            prev_addr  <= '0;
            prev_wdata <= '0;
        end else begin
            prev_we    <= inv_we;
            prev_addr  <= inv_addr;
            prev_wdata <= inv_wdata;
        end
    end

    // Controller write wins the cycle; apply_we is already masked by ctrl_commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= INIT_V;
            end
        end else if (ctrl_commit) begin
            stock[inv_idx] <= inv_wdata;
        end else if (apply_we) begin
            stock[item_idx] <= apply_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vend_count <= '0;
        end else if (ctrl_commit && vend_dec) begin
            vend_count <= vend_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            low_stock <= {NUM_ITEMS{INIT_LOW}};
            empty     <= {NUM_ITEMS{INIT_EMPTY}};
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                low_stock[i] <= (stock[i] <= LOW_V);
                empty[i]     <= (stock[i] == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_inventory_store.sv
// Randomized and directed bench for inventory_store against an array-based stock model;
// rs_done pulses are matched by a monitor against a queue of expected completion cycles.
module tb_inventory_store;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    inv_addr;
    logic [15:0]   inv_wdata;
    logic          inv_we;
    logic [15:0]   inv_rdata;
    logic          rs_valid;
    logic          rs_ready;
    logic [3:0]    rs_item;
    logic [15:0]   rs_qty;
    logic          rs_mode;
    logic          rs_done;
    logic [N-1:0]  low_stock;
    logic [N-1:0]  empty;
    logic [31:0]   vend_count;
    logic          rs_state;

    inventory_store #(
        .NUM_ITEMS(N), .INIT_STOCK(10), .LOW_THRESH(2), .MAX_STOCK(999)
    ) dut (
        .clk(clk), .rst(rst),
        .inv_addr(inv_addr), .inv_wdata(inv_wdata), .inv_we(inv_we), .inv_rdata(inv_rdata),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_item(rs_item), .rs_qty(rs_qty),
        .rs_mode(rs_mode), .rs_done(rs_done),
        .low_stock(low_stock), .empty(empty), .vend_count(vend_count), .rs_state(rs_state)
    );

    // clock / reset-free cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];

    // reference model state
    int       m_stock [N];
    int       m_vend;
    bit       m_ready, m_pend;
    int       m_item, m_qty;
    bit       m_mode;
    bit       m_pwe;
    int       m_paddr, m_pdata;
    bit [N-1:0] m_low, m_empty;

    function automatic void check(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic int model_read(int a);
        return (a < N) ? m_stock[a] : 0;
    endfunction

    function automatic int clamp(int v);
        return (v > 999) ? 999 : v;
    endfunction

    // Advance the model over the coming clock edge with the inputs as currently driven,
    // take the edge, then compare every observable output.
    task automatic cycle();
        bit commit;
        int a, d;
        a = int'(inv_addr);
        d = int'(inv_wdata);
        commit = !rst && inv_we && (a < N) && (!m_pwe || a != m_paddr || d != m_pdata);
        for (int i = 0; i < N; i++) begin
            m_low[i]   = (m_stock[i] <= 2);
            m_empty[i] = (m_stock[i] == 0);
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_stock[i] = 10;
                m_low[i]   = 1'b0;
                m_empty[i] = 1'b0;
            end
            m_vend = 0; m_pend = 0; m_ready = 0;
            m_pwe = 0; m_paddr = 0; m_pdata = 0;
        end else begin
            if (commit) begin
                if (d < m_stock[a]) m_vend = m_vend + 1;
                m_stock[a] = d;
            end else if (m_pend) begin
                if (m_item < N)
                    m_stock[m_item] = m_mode ? clamp(m_qty) : clamp(m_stock[m_item] + m_qty);
                exp_q.push_back(32'(cyc));
                m_pend = 0;
            end
            if (rs_valid && m_ready) begin
                m_item = int'(rs_item); m_qty = int'(rs_qty); m_mode = rs_mode;
                m_pend = 1;
            end
            m_ready = !m_pend;
            m_pwe = inv_we; m_paddr = a; m_pdata = d;
        end
        @(posedge clk);
        #1;
        check("rs_ready", rs_ready, m_ready);
        check("vend_count", vend_count, m_vend);
        check("low_stock", low_stock, m_low);
        check("empty", empty, m_empty);
        check("inv_rdata", inv_rdata, model_read(int'(inv_addr)));
    endtask

    task automatic idle(int n);
        inv_we = 0; rs_valid = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic read_check(int a);
        inv_addr = 8'(a);
        #1;
        check("read", inv_rdata, model_read(a));
    endtask

    task automatic const_read(string name, int a, int exp);
        inv_addr = 8'(a);
        #1;
        check(name, inv_rdata, exp);
    endtask

    // Waits (bounded) for the restock port to be free, then presents one request for
    // exactly the acceptance cycle; returns with the request in its apply phase.
    task automatic restock_issue(int item, int qty, bit mode);
        int waited = 0;
        while (!m_ready && waited < 8) begin
            cycle();
            waited++;
        end
        if (!m_ready) begin
            vectors++; miscompares++;
            $display("FAIL restock_wait: port busy after %0d cycles, required ready", waited);
        end
        rs_valid = 1; rs_item = 4'(item); rs_qty = 16'(qty); rs_mode = mode;
        cycle();
        rs_valid = 0;
    endtask

    // monitor: each rs_done pulse must match the next expected completion cycle
    always @(negedge clk) begin
        if (rs_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL rs_done: pulse at cycle %0d, required none", cyc);
            end else begin
                check("rs_done_cycle", cyc, exp_q.pop_front());
            end
        end else if (exp_q.size() > 0 && exp_q[0] <= 32'(cyc)) begin
            vectors++; miscompares++;
            $display("FAIL rs_done: no pulse at cycle %0d, required at %0d", cyc, exp_q[0]);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        rst = 1; inv_addr = 0; inv_wdata = 0; inv_we = 0;
        rs_valid = 0; rs_item = 0; rs_qty = 0; rs_mode = 0;
        cycle();
        cycle();
        rst = 0;
        cycle();
        for (int a = 0; a < N; a++) read_check(a);
        const_read("reset_rd0", 0, 10);
        const_read("reset_rd200", 200, 0);
        check("reset_low", low_stock, 0);
        check("reset_ready", rs_ready, 1);

        // held identical write commits once; restock during the hold is not clobbered
        inv_addr = 3; inv_wdata = 9; inv_we = 1;
        for (int k = 0; k < 20; k++) begin
            if (k == 4) begin
                rs_valid = 1; rs_item = 3; rs_qty = 5; rs_mode = 0;
            end else begin
                rs_valid = 0;
            end
            cycle();
        end
        idle(1);
        const_read("hold_stock3", 3, 14);
        check("hold_vend", vend_count, 1);

        // item 5 to low then empty
        inv_addr = 5; inv_wdata = 2; inv_we = 1; cycle();
        inv_we = 0; cycle();
        check("low5", low_stock[5], 1);
        check("empty5_not_yet", empty[5], 0);
        inv_addr = 5; inv_wdata = 0; inv_we = 1; cycle();
        inv_we = 0; cycle();
        check("empty5", empty[5], 1);
        check("vend_after5", vend_count, 3);

        // saturation on add and on set
        restock_issue(1, 995, 0);
        idle(2);
        const_read("sat_add", 1, 999);
        restock_issue(1, 2000, 1);
        idle(2);
        const_read("sat_set", 1, 999);

        // controller write in the apply cycle stalls the restock one cycle
        restock_issue(7, 6, 0);
        inv_addr = 7; inv_wdata = 4; inv_we = 1;
        cycle();
        inv_we = 0;
        idle(2);
        const_read("stall_stock7", 7, 10);

        // reset during apply discards the request
        inv_addr = 2; inv_wdata = 3; inv_we = 1; cycle();
        inv_we = 0; cycle();
        restock_issue(2, 50, 0);
        rst = 1; cycle();
        rst = 0; cycle();
        const_read("rst_stock2", 2, 10);
        check("rst_ready", rs_ready, 1);

        // randomized mix
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 249) == 0);
            inv_we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) != 0) begin
                inv_addr = ($urandom_range(0, 19) == 0) ? 8'd200 : 8'($urandom_range(0, 17));
                inv_wdata = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1100))
                                                        : 16'($urandom_range(0, 12));
            end
            rs_valid = $urandom_range(0, 1);
            rs_item = 4'($urandom_range(0, 15));
            rs_qty = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1200))
                                                 : 16'($urandom_range(0, 8));
            rs_mode = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 0;
        idle(4);
        for (int a = 0; a < N; a++) read_check(a);
        check("done_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
